// File: rtl/truth_table_pkg.sv
// Shared types and defaults for the truth-table stimulus sequencer.
package truth_table_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      DONE  = 2'd2
   } tt_state_t;

   localparam int          TT_NIN_DEF      = 3;
   // Golden response for Y = AB + A'B + B'C, which reduces to Y = B | C.
   localparam logic [7:0]  TT_EXPECTED_DEF = 8'hEE;

endpackage

// File: rtl/truth_table_sequencer_hold_timer.sv
// Hold-time down-counter: load sets the count, en counts toward zero, tc flags zero.
module tt_hold_timer #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] load_val,
   output logic         tc
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (en && (cnt != '0)) begin
         cnt <= cnt - W'(1);
      end
   end

   assign tc = (cnt == '0);

endmodule

// File: rtl/truth_table_sequencer.sv
// Walks all 2**NIN input vectors through the downstream circuit and captures Y per vector.
// Optional golden-word comparator on port pass is enabled by defining TT_SELFCHECK_EN.
//
//   state | meaning
//   IDLE  | waiting for start; resp holds the last result
//   DRIVE | presenting vec on a/b/c_out, sampling y_in on the last hold cycle
//   DONE  | one-cycle done pulse, stimulus outputs back at 0
module truth_table_sequencer
   import truth_table_pkg::*;
#(
   parameter int NIN         = TT_NIN_DEF,
   parameter int HOLD_CYCLES = 2
`ifdef TT_SELFCHECK_EN
   ,
   parameter logic [2**NIN-1:0] EXPECTED = TT_EXPECTED_DEF
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              y_in,
   output logic              a_out,
   output logic              b_out,
   output logic              c_out,
   output logic              busy,
   output logic              done,
   output logic [2**NIN-1:0] resp
`ifdef TT_SELFCHECK_EN
   ,
   output logic              pass
`endif
);

   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

   tt_state_t        state;
   logic [NIN-1:0]   vec;
   logic [NIN-1:0]   vec_inc;
   logic [2**NIN-1:0] resp_next;
   logic             accept;
   logic             hold_tc;
   logic             timer_load;

   always_comb begin
      accept          = (state == IDLE) && start;
      vec_inc         = vec + NIN'(1);
      resp_next       = resp;
      resp_next[vec]  = y_in;
      // Reload on the accepting edge and again after every sample so each vector gets a full hold.
      timer_load      = accept || ((state == DRIVE) && hold_tc);
   end

   tt_hold_timer #(
      .W (HW)
   ) u_hold_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (timer_load),
      .en       (state == DRIVE),
      .load_val (HW'(HOLD_CYCLES - 1)),
      .tc       (hold_tc)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         vec   <= '0;
         resp  <= '0;
         a_out <= 1'b0;
         b_out <= 1'b0;
         c_out <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
`ifdef TT_SELFCHECK_EN
         pass  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state <= DRIVE;
                  vec   <= '0;
                  resp  <= '0;
                  a_out <= 1'b0;
                  b_out <= 1'b0;
                  c_out <= 1'b0;
                  busy  <= 1'b1;
`ifdef TT_SELFCHECK_EN
                  pass  <= 1'b0;
`endif
               end
            end
            DRIVE: begin
               if (hold_tc) begin
                  resp <= resp_next;
                  if (vec == '1) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     a_out <= 1'b0;
                     b_out <= 1'b0;
                     c_out <= 1'b0;
`ifdef TT_SELFCHECK_EN
                     pass  <= (resp_next == EXPECTED);
`endif
                  end else begin
                     vec   <= vec_inc;
                     a_out <= vec_inc[NIN-1];
                     b_out <= vec_inc[1];
                     c_out <= vec_inc[0];
                  end
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
